// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: state encoding, parity constants, defaults and vote helper for the UART receiver
package uart_rx_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD = 1'b1;
    localparam int DEF_PRESCALE = 8;
    localparam int DEF_DATA_WIDTH = 8;
    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter and three-sample majority vote around mid-bit
module uart_rx_sampler import uart_rx_pkg::*; #(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic line,
    output logic sampled_bit,
    output logic bit_tick
);
    localparam int EW = $clog2(PRESCALE);
    localparam logic [EW-1:0] LAST = EW'(PRESCALE - 1);
    localparam logic [EW-1:0] S_LO = EW'(PRESCALE / 2 - 1);
    localparam logic [EW-1:0] S_MID = EW'(PRESCALE / 2);
    localparam logic [EW-1:0] S_HI = EW'(PRESCALE / 2 + 1);
    logic [EW-1:0] edge_cnt;
    logic [2:0] samples;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
            samples <= '1;
        end else begin
            edge_cnt <= (en && edge_cnt != LAST) ? edge_cnt + EW'(1) : '0;
            if (en && edge_cnt == S_LO) samples[0] <= line;
            if (en && edge_cnt == S_MID) samples[1] <= line;
            if (en && edge_cnt == S_HI) samples[2] <= line;
        end
    end
    assign bit_tick = en && edge_cnt == LAST;
    assign sampled_bit = majority3(samples);
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with parity and stop-bit checking
module uart_rx import uart_rx_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  par_err,
    output logic                  stp_err
);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    state_t state, state_nxt;
    logic [1:0] sync;
    logic line, sampled_bit, bit_tick;
    logic par_en_l, par_typ_l, par_mis;
    logic [BW-1:0] bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '1;
        else sync <= {sync[0], RX_IN};
    end
    assign line = sync[1];
    uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
        .clk(clk),
        .rst(rst),
        .en(state != IDLE),
        .line(line),
        .sampled_bit(sampled_bit),
        .bit_tick(bit_tick)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = line ? IDLE : START;
            START:   if (bit_tick) state_nxt = sampled_bit ? IDLE : DATA;
            DATA:    if (bit_tick && bit_cnt == BIT_LAST) state_nxt = par_en_l ? PARITY : STOP;
            PARITY:  if (bit_tick) state_nxt = STOP;
            STOP:    if (bit_tick) state_nxt = line ? IDLE : START;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            shreg <= '0;
            par_en_l <= 1'b0;
            par_typ_l <= PAR_EVEN;
            par_mis <= 1'b0;
            P_DATA <= '0;
            Data_Valid <= 1'b0;
            par_err <= 1'b0;
            stp_err <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            if (state_nxt == START && state != START) begin
                par_en_l <= PAR_EN;
                par_typ_l <= PAR_TYP;
                par_mis <= 1'b0;
            end
            // a STOP->START hop keeps the flags just written; only a fresh start clears them
            if (state == IDLE && state_nxt == START) begin
                par_err <= 1'b0;
                stp_err <= 1'b0;
            end
            if (bit_tick && state == START) bit_cnt <= '0;
            if (bit_tick && state == DATA) begin
                shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
                bit_cnt <= (bit_cnt == BIT_LAST) ? bit_cnt : bit_cnt + BW'(1);
            end
            if (bit_tick && state == PARITY)
                par_mis <= ((^shreg) ^ (par_typ_l == PAR_ODD)) != sampled_bit;
            if (bit_tick && state == STOP) begin
                stp_err <= ~sampled_bit;
                par_err <= par_en_l & par_mis;
                if (sampled_bit && !(par_en_l && par_mis)) begin
                    P_DATA <= shreg;
                    Data_Valid <= 1'b1;
                end
            end
        end
    end
endmodule
